ps2_led_sequencer: RTL and testbench

Host-to-keyboard command sequencer for the PS/2 path. Drives the PS2_Controller transmit side (`the_command` / `send_command`) to issue the Set-LEDs command (0xED followed by an LED byte), waits for each keyboard acknowledge, and retries on resend or timeout. It sits between PS2_Controller and the protector/display consumers. While sequencing, it absorbs ACK/RESEND bytes and forwards every other received byte unchanged, so acknowledges are never decoded as keystrokes.

---
 rtl/ps2_led_sequencer_pkg.sv | 23 ++
 rtl/ps2_ack_timer.sv | 28 ++
 rtl/ps2_led_sequencer.sv | 135 +++++++++++++
 tb/tb_ps2_led_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_led_sequencer_pkg.sv
// Shared PS/2 command bytes and sequencer state encoding.
package ps2_led_sequencer_pkg;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_ACK         = 8'hFA;
  localparam logic [7:0] PS2_RESEND      = 8'hFE;

  typedef enum logic [2:0] {
    IDLE,
    TX_CMD,
    WAIT_CMD_SENT,
    WAIT_CMD_ACK,
    TX_ARG,
    WAIT_ARG_SENT,
    WAIT_ARG_ACK,
    FINISH
  } seq_state_t;

  function automatic logic [7:0] led_byte(input logic [2:0] l);
    return {5'b0, l};
  endfunction

endpackage

// File: rtl/ps2_ack_timer.sv
// Clearable ACK wait counter; expired holds once the limit is hit.
module ps2_ack_timer #(
  parameter int unsigned ACK_TIMEOUT = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [19:0] LIMIT = 20'(ACK_TIMEOUT);

  logic [19:0] cnt;

  assign expired = (cnt == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 20'd1;
    end
  end

endmodule

// File: rtl/ps2_led_sequencer.sv
// Set-LEDs command sequencer with ACK/RESEND handling and rx filter.
import ps2_led_sequencer_pkg::*;

module ps2_led_sequencer #(
  parameter int unsigned ACK_TIMEOUT = 1_000_000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [2:0] led_state,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] the_command,
  output logic       send_command,
  input  logic       command_was_sent,
  input  logic       error_communication_timed_out,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic [7:0] rx_pass_data,
  output logic       rx_pass_en
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

  seq_state_t state, state_n;
  logic [RW-1:0] retry_q;
  logic [7:0] cur_led, next_led;
  logic pending;
  logic in_ack, expired, is_ack, is_resend;
  logic retry_fire, give_up, fwd;

  assign in_ack = (state == WAIT_CMD_ACK) || (state == WAIT_ARG_ACK);
  assign is_ack = received_data_en && (received_data == PS2_ACK);
  assign is_resend = received_data_en && (received_data == PS2_RESEND);
  assign fwd = received_data_en && !(in_ack && (received_data == PS2_ACK ||
                                                received_data == PS2_RESEND));

  assign busy = (state != IDLE) && (state != FINISH);
  assign done = (state == FINISH);
  assign send_command = (state == TX_CMD) || (state == TX_ARG);

  ps2_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_timer (
    .clk(clk),
    .rst_n(reset),
    .clr(!in_ack),
    .en(in_ack),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    retry_fire = 1'b0;
    give_up    = 1'b0;
    unique case (state)
      IDLE:          if (req) state_n = TX_CMD;
      TX_CMD:        state_n = WAIT_CMD_SENT;
      TX_ARG:        state_n = WAIT_ARG_SENT;
      WAIT_CMD_SENT: begin
        if (error_communication_timed_out) retry_fire = 1'b1;
        else if (command_was_sent) state_n = WAIT_CMD_ACK;
      end
      WAIT_ARG_SENT: begin
        if (error_communication_timed_out) retry_fire = 1'b1;
        else if (command_was_sent) state_n = WAIT_ARG_ACK;
      end
      WAIT_CMD_ACK: begin
        if (is_ack) state_n = TX_ARG;
        else if (is_resend || expired) retry_fire = 1'b1;
      end
      WAIT_ARG_ACK: begin
        if (is_ack) state_n = FINISH;
        else if (is_resend || expired) retry_fire = 1'b1;
      end
      FINISH:        state_n = (pending || req) ? TX_CMD : IDLE;
      default:       state_n = IDLE;
    endcase
    // Every retry restarts the whole exchange from the command byte
    if (retry_fire) begin
      if (retry_q < RMAX) begin
        state_n = TX_CMD;
      end else begin
        state_n = IDLE;
        give_up = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retry_q      <= '0;
      err          <= 1'b0;
      the_command  <= '0;
      cur_led      <= '0;
      next_led     <= '0;
      pending      <= 1'b0;
      rx_pass_en   <= 1'b0;
      rx_pass_data <= '0;
    end else begin
      err        <= give_up;
      rx_pass_en <= fwd;
      if (fwd) rx_pass_data <= received_data;

      if (state == IDLE || state == FINISH) retry_q <= '0;
      else if (retry_fire && !give_up) retry_q <= retry_q + RW'(1);

      if (state_n == TX_CMD) the_command <= PS2_CMD_SET_LED;
      else if (state_n == TX_ARG) the_command <= cur_led;

      if (state == IDLE) begin
        if (req) cur_led <= led_byte(led_state);
        pending <= 1'b0;
      end else if (state == FINISH) begin
        if (req) cur_led <= led_byte(led_state);
        else if (pending) cur_led <= next_led;
        pending <= 1'b0;
      end else if (give_up) begin
        pending <= 1'b0;
      end else if (req) begin
        next_led <= led_byte(led_state);
        pending  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_led_sequencer.sv
// Directed bench for ps2_led_sequencer with a scripted keyboard.
module tb_ps2_led_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic [2:0] led_state = '0;
  logic       busy, done, err, send_command, rx_pass_en;
  logic [7:0] the_command, rx_pass_data;
  logic       command_was_sent = 1'b0;
  logic       error_communication_timed_out = 1'b0;
  logic [7:0] received_data = '0;
  logic       received_data_en = 1'b0;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [7:0] sent_q[$];

  typedef struct {
    logic [7:0] data;
    logic       en;
    logic       exp_en;
    logic [7:0] exp_data;
  } vec_t;

  ps2_led_sequencer #(
    .ACK_TIMEOUT(50),
    .MAX_RETRY(3)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .req(req),
    .led_state(led_state),
    .busy(busy),
    .done(done),
    .err(err),
    .the_command(the_command),
    .send_command(send_command),
    .command_was_sent(command_was_sent),
    .error_communication_timed_out(error_communication_timed_out),
    .received_data(received_data),
    .received_data_en(received_data_en),
    .rx_pass_data(rx_pass_data),
    .rx_pass_en(rx_pass_en)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (send_command) sent_q.push_back(the_command);
    if (done) done_cnt++;
    if (err) err_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_sent(input string name, input logic [7:0] exp[$]);
    chk({name, "_count"}, sent_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < sent_q.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), sent_q[i], exp[i]);
  endtask

  task automatic start_req(input logic [2:0] l);
    req = 1'b1;
    led_state = l;
    tick();
    req = 1'b0;
  endtask

  // Wait for a strobe, check the byte, complete the transfer, optionally reply
  task automatic handle_tx(input logic [7:0] exp, input logic [7:0] reply,
                           input bit do_reply);
    int n = 0;
    while (!send_command && n < 200) begin
      tick();
      n++;
    end
    if (!send_command) begin
      checks++;
      failures++;
      $display("FAIL send_wait: got no strobe required byte %0h", exp);
      return;
    end
    chk("tx_byte", the_command, exp);
    tick();
    command_was_sent = 1'b1;
    tick();
    command_was_sent = 1'b0;
    if (do_reply) begin
      received_data = reply;
      received_data_en = 1'b1;
      tick();
      received_data_en = 1'b0;
    end
  endtask

  task automatic settle();
    repeat (3) tick();
    sent_q.delete();
    done_cnt = 0;
    err_cnt = 0;
  endtask

  initial begin
    vec_t vecs[5];
    logic [7:0] exp_q[$];
    int n, d0;

    vecs[0] = '{data: 8'hFA, en: 1'b1, exp_en: 1'b1, exp_data: 8'hFA};
    vecs[1] = '{data: 8'h33, en: 1'b0, exp_en: 1'b0, exp_data: 8'h00};
    vecs[2] = '{data: 8'hFE, en: 1'b1, exp_en: 1'b1, exp_data: 8'hFE};
    vecs[3] = '{data: 8'h1C, en: 1'b1, exp_en: 1'b1, exp_data: 8'h1C};
    vecs[4] = '{data: 8'h5A, en: 1'b0, exp_en: 1'b0, exp_data: 8'h00};

    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_send", send_command, 0);
    chk("rst_cmd", the_command, 0);
    chk("rst_pass_en", rx_pass_en, 0);
    rst_n = 1'b1;
    settle();

    // Normal update
    start_req(3'b100);
    chk("norm_busy", busy, 1);
    handle_tx(8'hED, 8'hFA, 1);
    handle_tx(8'h04, 8'hFA, 1);
    chk("norm_done", done, 1);
    chk("norm_busy_fall", busy, 0);
    tick();
    chk("norm_done_once", done, 0);
    exp_q = {8'hED, 8'h04};
    chk_sent("norm", exp_q);
    chk("norm_done_cnt", done_cnt, 1);
    chk("norm_err_cnt", err_cnt, 0);
    settle();

    // Resend on the argument byte
    start_req(3'b100);
    handle_tx(8'hED, 8'hFA, 1);
    handle_tx(8'h04, 8'hFE, 1);
    handle_tx(8'hED, 8'hFA, 1);
    handle_tx(8'h04, 8'hFA, 1);
    tick();
    exp_q = {8'hED, 8'h04, 8'hED, 8'h04};
    chk_sent("resend", exp_q);
    chk("resend_done_cnt", done_cnt, 1);
    settle();

    // Retries exhausted by ACK timeout
    start_req(3'b100);
    repeat (4) handle_tx(8'hED, 8'h00, 0);
    n = 0;
    while (!err && n < 200) begin
      tick();
      n++;
    end
    chk("exh_err", err, 1);
    chk("exh_busy", busy, 0);
    tick();
    chk("exh_err_once", err, 0);
    exp_q = {8'hED, 8'hED, 8'hED, 8'hED};
    chk_sent("exh", exp_q);
    chk("exh_done_cnt", done_cnt, 0);
    settle();

    // Filtering during WAIT_CMD_ACK
    start_req(3'b100);
    handle_tx(8'hED, 8'h1C, 1);
    chk("filt_fwd_en", rx_pass_en, 1);
    chk("filt_fwd_data", rx_pass_data, 8'h1C);
    received_data = 8'hFA;
    received_data_en = 1'b1;
    tick();
    received_data_en = 1'b0;
    chk("filt_ack_eaten", rx_pass_en, 0);
    chk("filt_next_tx", send_command, 1);
    handle_tx(8'h04, 8'hFA, 1);
    chk("filt_done", done, 1);
    settle();

    // Pass-through in IDLE
    foreach (vecs[i]) begin
      received_data = vecs[i].data;
      received_data_en = vecs[i].en;
      tick();
      received_data_en = 1'b0;
      chk($sformatf("idle_en%0d", i), rx_pass_en, vecs[i].exp_en);
      if (vecs[i].exp_en)
        chk($sformatf("idle_data%0d", i), rx_pass_data, vecs[i].exp_data);
      tick();
      chk($sformatf("idle_pulse%0d", i), rx_pass_en, 0);
    end
    settle();

    // Pending request during WAIT_ARG_ACK
    start_req(3'b100);
    handle_tx(8'hED, 8'hFA, 1);
    handle_tx(8'h04, 8'h00, 0);
    start_req(3'b011);
    received_data = 8'hFA;
    received_data_en = 1'b1;
    tick();
    received_data_en = 1'b0;
    chk("pend_done1", done, 1);
    handle_tx(8'hED, 8'hFA, 1);
    handle_tx(8'h03, 8'hFA, 1);
    chk("pend_done2", done, 1);
    tick();
    exp_q = {8'hED, 8'h04, 8'hED, 8'h03};
    chk_sent("pend", exp_q);
    chk("pend_done_cnt", done_cnt, 2);
    settle();

    // Reset in WAIT_ARG_SENT
    start_req(3'b100);
    handle_tx(8'hED, 8'hFA, 1);
    chk("rstm_tx_arg", send_command, 1);
    tick();
    d0 = done_cnt;
    n = sent_q.size();
    rst_n = 1'b0;
    #1;
    chk("rstm_busy", busy, 0);
    chk("rstm_send", send_command, 0);
    chk("rstm_cmd", the_command, 0);
    chk("rstm_done", done, 0);
    chk("rstm_err", err, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("rstm_no_strobe", sent_q.size(), n);
    chk("rstm_no_done", done_cnt, d0);
    chk("rstm_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
